// File: rtl/rf_wb_scheduler.sv
// Register-file write-port arbiter: ALU writeback has priority, long-unit results
// queue in a small FIFO and drain in free cycles; a scoreboard stalls hazardous issue.
module rf_wb_scheduler #(
  parameter int unsigned LU_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  output logic        issue_stall,
  input  logic        alu_we,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wd,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_wd,
  output logic        alu_hold,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] pending
);

  localparam int unsigned PTR_W = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(LU_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       r_fifo_rd [LU_DEPTH];
  logic [31:0]      r_fifo_wd [LU_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pending;
  logic [STV_W-1:0] r_starve;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_sb_set;
  logic [4:0]  w_head_rd;
  logic [31:0] w_head_wd;
  logic [31:0] w_pend_nxt;

  assign w_empty   = (r_count == CNT_W'(0));
  assign w_full    = (r_count == CNT_W'(LU_DEPTH));
  assign w_head_rd = r_fifo_rd[r_rptr];
  assign w_head_wd = r_fifo_wd[r_rptr];
  assign w_push    = lu_valid && !w_full;

  assign lu_ready    = !w_full;
  assign pending     = r_pending;
  assign alu_hold    = (r_starve >= STV_W'(STARVE_LIMIT));
  assign issue_stall = issue_valid &&
                       (r_pending[issue_rs1] || r_pending[issue_rs2] || r_pending[issue_rd]);
  assign w_sb_set    = issue_valid && !issue_stall && issue_long && (issue_rd != 5'd0);

  // Write-port arbitration; x0 destinations are consumed without a regfile write.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = 32'd0;
    w_pop = 1'b0;
    if (!reset) begin
      if (alu_we) begin
        rf_we = (alu_rd != 5'd0);
        rf_wa = alu_rd;
        rf_wd = alu_wd;
      end else if (!w_empty) begin
        rf_we = (w_head_rd != 5'd0);
        rf_wa = w_head_rd;
        rf_wd = w_head_wd;
        w_pop = 1'b1;
      end
    end
  end

  // Scoreboard update: a new long issue to the same register overrides the clear.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_pop) w_pend_nxt[w_head_rd] = 1'b0;
    if (w_sb_set) w_pend_nxt[issue_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr] <= lu_rd;
      r_fifo_wd[r_wptr] <= lu_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_starve  <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // Count consecutive cycles the queued head loses the port to the ALU.
      if (w_empty || w_pop)
        r_starve <= '0;
      else if (alu_we && (r_starve != STV_W'(STARVE_LIMIT)))
        r_starve <= r_starve + STV_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler with hand-computed expectations.
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wd;
  logic        alu_hold;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pending;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.LU_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_stall(issue_stall),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wd(lu_wd),
    .alu_hold(alu_hold),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .pending(pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_long = 1'b0;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    alu_we = 1'b0; alu_rd = 5'd0; alu_wd = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_wd = 32'd0;
  endtask

  task automatic lu_push(input logic [4:0] rd, input logic [31:0] wd);
    lu_valid = 1'b1; lu_rd = rd; lu_wd = wd;
  endtask

  task automatic alu_wr(input logic [4:0] rd, input logic [31:0] wd);
    alu_we = 1'b1; alu_rd = rd; alu_wd = wd;
  endtask

  task automatic issue(input logic lng, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd);
    issue_valid = 1'b1; issue_long = lng;
    issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
  endtask

  // An ALU write to a register with an outstanding long write must never occur.
  always @(negedge clk) begin
    if (!reset && alu_we && alu_rd != 5'd0)
      chk("alu_waw", 32'(pending[alu_rd]), 32'd0);
  end

  initial begin
    idle();
    reset = 1'b1;
    alu_wr(5'd3, 32'h33);
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_wa", 32'(rf_wa), 32'd0);
    chk("rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("rst_pending", pending, 32'd0);
    chk("rst_alu_hold", 32'(alu_hold), 32'd0);
    cyc();
    idle();
    reset = 1'b0;
    #1;
    chk("post_rst_rf_we", 32'(rf_we), 32'd0);
    chk("post_rst_stall", 32'(issue_stall), 32'd0);

    // Reset arriving while a long result is queued and pending.
    issue(1'b1, 5'd0, 5'd0, 5'd5);
    lu_push(5'd5, 32'h11);
    cyc();
    idle();
    #1;
    chk("mid_pend_set", pending, 32'h20);
    chk("mid_head_wa", 32'(rf_wa), 32'd5);
    reset = 1'b1;
    #1;
    chk("mid_rst_pend", pending, 32'd0);
    chk("mid_rst_rf_we", 32'(rf_we), 32'd0);
    chk("mid_rst_ready", 32'(lu_ready), 32'd1);
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_rel_rf_we", 32'(rf_we), 32'd0);
    chk("mid_rel_pend", pending, 32'd0);

    // RAW stall on x7 until the long result has been written.
    issue(1'b1, 5'd0, 5'd0, 5'd7);
    #1;
    chk("raw_first_stall", 32'(issue_stall), 32'd0);
    cyc();
    issue(1'b0, 5'd7, 5'd0, 5'd8);
    lu_push(5'd7, 32'hDEAD);
    #1;
    chk("raw_pend", pending, 32'h80);
    chk("raw_stall", 32'(issue_stall), 32'd1);
    chk("raw_lu_ready", 32'(lu_ready), 32'd1);
    cyc();
    lu_valid = 1'b0;
    #1;
    chk("raw_n1_we", 32'(rf_we), 32'd1);
    chk("raw_n1_wa", 32'(rf_wa), 32'd7);
    chk("raw_n1_wd", rf_wd, 32'hDEAD);
    chk("raw_n1_stall", 32'(issue_stall), 32'd1);
    cyc();
    #1;
    chk("raw_n2_stall", 32'(issue_stall), 32'd0);
    chk("raw_n2_pend", pending, 32'd0);
    chk("raw_n2_we", 32'(rf_we), 32'd0);
    idle();

    // Continuous ALU traffic starves the queue until alu_hold forces a bubble.
    alu_wr(5'd1, 32'h100);
    lu_push(5'd10, 32'hA0);
    #1;
    chk("stv_c0_wa", 32'(rf_wa), 32'd1);
    cyc();
    alu_wr(5'd1, 32'h101);
    lu_push(5'd11, 32'hB0);
    #1;
    chk("stv_c1_alu_wins", 32'(rf_wa), 32'd1);
    chk("stv_c1_wd", rf_wd, 32'h101);
    chk("stv_c1_ready", 32'(lu_ready), 32'd1);
    cyc();
    alu_wr(5'd1, 32'h102);
    lu_push(5'd12, 32'hC0);
    #1;
    chk("stv_c2_full", 32'(lu_ready), 32'd0);
    cyc();
    lu_valid = 1'b0;
    alu_wr(5'd1, 32'h103);
    #1;
    chk("stv_c3_hold", 32'(alu_hold), 32'd0);
    cyc();
    alu_wr(5'd1, 32'h104);
    #1;
    chk("stv_c4_hold", 32'(alu_hold), 32'd0);
    cyc();
    alu_wr(5'd1, 32'h105);
    #1;
    chk("stv_c5_hold", 32'(alu_hold), 32'd1);
    cyc();
    alu_we = 1'b0;
    #1;
    chk("stv_c6_hold", 32'(alu_hold), 32'd1);
    chk("stv_c6_we", 32'(rf_we), 32'd1);
    chk("stv_c6_wa", 32'(rf_wa), 32'd10);
    chk("stv_c6_wd", rf_wd, 32'hA0);
    cyc();
    #1;
    chk("stv_c7_hold", 32'(alu_hold), 32'd0);
    chk("stv_c7_wa", 32'(rf_wa), 32'd11);
    chk("stv_c7_wd", rf_wd, 32'hB0);
    cyc();
    #1;
    chk("stv_c8_empty", 32'(rf_we), 32'd0);
    idle();

    // ALU collides with a queued head; pending clears only on the real write.
    issue(1'b1, 5'd0, 5'd0, 5'd9);
    cyc();
    idle();
    lu_push(5'd9, 32'h99);
    cyc();
    lu_valid = 1'b0;
    alu_wr(5'd2, 32'h22);
    #1;
    chk("col_alu_wa", 32'(rf_wa), 32'd2);
    chk("col_alu_wd", rf_wd, 32'h22);
    chk("col_pend_held", pending, 32'h200);
    cyc();
    alu_we = 1'b0;
    #1;
    chk("col_head_wa", 32'(rf_wa), 32'd9);
    chk("col_head_wd", rf_wd, 32'h99);
    chk("col_pend_still", pending, 32'h200);
    cyc();
    #1;
    chk("col_pend_clr", pending, 32'd0);
    idle();

    // x0 destinations: no scoreboard entry and no regfile write.
    issue(1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    chk("x0_stall", 32'(issue_stall), 32'd0);
    cyc();
    idle();
    lu_push(5'd0, 32'h55);
    #1;
    chk("x0_pend", pending, 32'd0);
    cyc();
    lu_push(5'd13, 32'h13);
    #1;
    chk("x0_head_we", 32'(rf_we), 32'd0);
    chk("x0_head_wa", 32'(rf_wa), 32'd0);
    cyc();
    lu_valid = 1'b0;
    #1;
    chk("x0_popped_wa", 32'(rf_wa), 32'd13);
    chk("x0_popped_wd", rf_wd, 32'h13);
    cyc();
    alu_wr(5'd0, 32'hFF);
    #1;
    chk("x0_alu_we", 32'(rf_we), 32'd0);
    cyc();
    idle();

    // Full FIFO: pop with lu_valid held does not push until lu_ready returns.
    alu_wr(5'd1, 32'h1);
    lu_push(5'd14, 32'hE0);
    cyc();
    lu_push(5'd15, 32'hE1);
    cyc();
    alu_we = 1'b0;
    lu_push(5'd16, 32'hE2);
    #1;
    chk("full_ready", 32'(lu_ready), 32'd0);
    chk("full_head_wa", 32'(rf_wa), 32'd14);
    cyc();
    #1;
    chk("full_ready_back", 32'(lu_ready), 32'd1);
    chk("full_e1_wa", 32'(rf_wa), 32'd15);
    chk("full_e1_wd", rf_wd, 32'hE1);
    cyc();
    lu_valid = 1'b0;
    #1;
    chk("full_e2_wa", 32'(rf_wa), 32'd16);
    chk("full_e2_wd", rf_wd, 32'hE2);
    cyc();
    #1;
    chk("full_drained", 32'(rf_we), 32'd0);
    idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
